fetch_buffer: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle core's decode/extend path.
- Issues word-aligned reads to instruction memory over a req/gnt/rvalid handshake and buffers the returned halfwords in a FIFO.
- Reassembles 16-bit and 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Presents one instruction per handshake, with its PC, to the core; on a core redirect (branch/jump) it flushes the FIFO and refetches.

---
 rtl/fetch_buffer.sv | 147 ++++++++++++++
 tb/tb_fetch_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: word fetch from imem into a halfword FIFO, reassembles 16/32-bit instructions (16-bit only with FETCH_RVC_EN).
// Latency: a response word is presentable the cycle after it arrives; the instruction output path is combinational.
// Backpressure: instr_ready_i low holds the head; no request is issued unless two halfword slots are free after any pop.
module fetch_buffer #(
    parameter int unsigned        RegBits   = 32,
    parameter int unsigned        DepthHalf = 8,
    parameter logic [RegBits-1:0] ResetPc   = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [RegBits-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [RegBits-1:0] mem_rdata_i,
    input  logic               redirect_i,
    input  logic [RegBits-1:0] redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [RegBits-1:0] instr_o,
    output logic [RegBits-1:0] instr_pc_o,
    output logic               instr_compressed_o
);

    localparam int unsigned     PtrW     = $clog2(DepthHalf);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] ReqLimit = CntW'(DepthHalf - 2);
    localparam logic [CntW:0]   FillMax  = (CntW + 1)'(DepthHalf);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;
    state_e state_q, state_d;

    logic [15:0]        buf_q [DepthHalf];
    logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]    count_q;
    logic [RegBits-1:0] fetch_addr_q, head_pc_q;
    logic               drop_low_q;
    logic               run_q;

    logic [15:0]     h0, h1;
    logic            is_32;
    logic [CntW-1:0] need, pop_n, push_n;
    logic [CntW:0]   fill_next;
    logic            fire, accept, gnt_fire;

    assign h0 = buf_q[rd_ptr_q];
    assign h1 = buf_q[rd_ptr_q + PtrW'(1)];

`ifdef FETCH_RVC_EN
    assign is_32 = (h0[1:0] == 2'b11);
`else
    assign is_32 = 1'b1;
`endif

    assign need          = is_32 ? CntW'(2) : CntW'(1);
    assign instr_valid_o = !redirect_i && (count_q >= need);
    assign fire          = instr_valid_o && instr_ready_i;
    assign pop_n         = fire ? need : '0;

    // run_q keeps the request low in the first cycle out of reset so every output reads 0 while reset is held
    assign mem_req_o  = run_q && (state_q == S_REQ) && !redirect_i && ((count_q - pop_n) <= ReqLimit);
    assign mem_addr_o = mem_req_o ? fetch_addr_q : '0;
    assign gnt_fire   = mem_req_o && mem_gnt_i;

    assign accept = (state_q == S_WAIT) && mem_rvalid_i && !redirect_i;
    assign push_n = !accept ? '0 : (drop_low_q ? CntW'(1) : CntW'(2));

    assign instr_o            = !instr_valid_o ? '0 : (is_32 ? RegBits'({h1, h0}) : RegBits'(h0));
    assign instr_pc_o         = instr_valid_o ? head_pc_q : '0;
    assign instr_compressed_o = instr_valid_o && !is_32;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            // a response still in flight must be swallowed before the new stream starts
            state_d = ((state_q != S_REQ) && !mem_rvalid_i) ? S_DRAIN : S_REQ;
        end else begin
            case (state_q)
                S_REQ:   if (gnt_fire) state_d = S_WAIT;
                S_WAIT:  if (mem_rvalid_i) state_d = S_REQ;
                S_DRAIN: if (mem_rvalid_i) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fetch_addr_q <= ResetPc;
            head_pc_q    <= ResetPc;
            drop_low_q   <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_i) begin
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                count_q      <= '0;
                head_pc_q    <= redirect_pc_i;
                fetch_addr_q <= {redirect_pc_i[RegBits-1:2], 2'b00};
`ifdef FETCH_RVC_EN
                drop_low_q   <= redirect_pc_i[1];
`else
                drop_low_q   <= 1'b0;
`endif
            end else begin
                if (gnt_fire) fetch_addr_q <= fetch_addr_q + RegBits'(4);
                if (accept)   drop_low_q   <= 1'b0;
                rd_ptr_q  <= rd_ptr_q + PtrW'(pop_n);
                wr_ptr_q  <= wr_ptr_q + PtrW'(push_n);
                count_q   <= count_q + push_n - pop_n;
                head_pc_q <= head_pc_q + RegBits'({pop_n, 1'b0});
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (drop_low_q) begin
                buf_q[wr_ptr_q] <= mem_rdata_i[31:16];
            end else begin
                buf_q[wr_ptr_q]             <= mem_rdata_i[15:0];
                buf_q[wr_ptr_q + PtrW'(1)]  <= mem_rdata_i[31:16];
            end
        end
    end

    assign fill_next = {1'b0, count_q} + {1'b0, push_n} - {1'b0, pop_n};

    always_ff @(posedge clk_i) begin
        if (rst_i && accept) begin
            assert (fill_next <= FillMax);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a responder with configurable latency feeds words, instructions are checked against hand-computed values.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_compressed_o;

    always #5 clk = ~clk;

    fetch_buffer #(.RegBits(32), .DepthHalf(8), .ResetPc(32'h0000_0000)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .redirect_i         (redirect_i),
        .redirect_pc_i      (redirect_pc_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_compressed_o (instr_compressed_o)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] words [128];
    int          rsp_lat = 1;
    int          cyc = 0;
    int          due_q [$];
    logic [31:0] addr_q [$];
    logic [31:0] gnt_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // memory responder: grants are sampled mid-cycle, responses return rsp_lat cycles later in order
    initial begin
        logic [31:0] a;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o && mem_gnt_i) begin
                due_q.push_back(cyc + rsp_lat);
                addr_q.push_back(mem_addr_o);
                gnt_log.push_back(mem_addr_o);
            end
            @(posedge clk);
            #1;
            cyc++;
            mem_rvalid_i = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                a            = addr_q[0];
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = words[a[8:2]];
                void'(due_q.pop_front());
                void'(addr_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        mem_gnt_i     = 1'b1;
        rst_i         = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_i = 1'b1;
        gnt_log.delete();
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 128; i++) words[i] = 32'h0000_0013;
    endtask

    // expects instr_ready_i=1; returns at posedge+1 after the handshake edge
    task automatic get_instr(input string tag, input logic [31:0] e_ins, input logic [31:0] e_pc, input logic e_c);
        int n = 0;
        @(negedge clk);
        while (!instr_valid_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, 32'(instr_valid_o), 32'd1);
        check({tag, "_ins"}, instr_o, e_ins);
        check({tag, "_pc"}, instr_pc_o, e_pc);
        check({tag, "_c"}, 32'(instr_compressed_o), 32'(e_c));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int cnt);
        int n = 0;
        @(negedge clk);
        while (gnt_log.size() < cnt && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("gnt_wait", 32'(gnt_log.size() >= cnt), 32'd1);
    endtask

    initial begin
        rst_i         = 1'b0;
        mem_gnt_i     = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        fill_nop();

        // reset values
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_vld", 32'(instr_valid_o), 32'd0);
        check("rst_ins", instr_o, 32'h0);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_c", 32'(instr_compressed_o), 32'd0);

        // grant stall then aligned 32-bit stream
        words[0]  = 32'h0050_0093;
        words[1]  = 32'h0010_8113;
        mem_gnt_i = 1'b0;
        instr_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        gnt_log.delete();
        repeat (3) @(negedge clk);
        check("stall_req", 32'(mem_req_o), 32'd1);
        check("stall_addr", mem_addr_o, 32'h0);
        check("stall_vld", 32'(instr_valid_o), 32'd0);
        @(posedge clk);
        #1;
        mem_gnt_i = 1'b1;
        get_instr("s1a", 32'h0050_0093, 32'h0, 1'b0);
        get_instr("s1b", 32'h0010_8113, 32'h4, 1'b0);
        repeat (4) @(posedge clk);
        check("s1_ngnt", 32'(gnt_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < gnt_log.size(); i++)
            check($sformatf("s1_addr%0d", i), gnt_log[i], 32'(4 * i));

`ifdef FETCH_RVC_EN
        // two compressed halves in one word, then a 32-bit word
        fill_nop();
        words[0] = 32'h4505_0505;
        do_reset();
        instr_ready_i = 1'b1;
        get_instr("s2a", 32'h0000_0505, 32'h0, 1'b1);
        get_instr("s2b", 32'h0000_4505, 32'h2, 1'b1);
        get_instr("s2c", 32'h0000_0013, 32'h4, 1'b0);

        // 32-bit instruction straddling a word boundary
        fill_nop();
        words[0] = 32'h0093_4501;
        words[1] = 32'hABCD_0050;
        do_reset();
        instr_ready_i = 1'b1;
        get_instr("s3a", 32'h0000_4501, 32'h0, 1'b1);
        get_instr("s3b", 32'h0050_0093, 32'h2, 1'b0);
        get_instr("s3c", 32'h0000_ABCD, 32'h6, 1'b1);
`else
        // without compressed support every word is one 32-bit instruction
        fill_nop();
        words[0] = 32'h4505_0505;
        do_reset();
        instr_ready_i = 1'b1;
        get_instr("s2a", 32'h4505_0505, 32'h0, 1'b0);
        get_instr("s2b", 32'h0000_0013, 32'h4, 1'b0);
`endif

        // backpressure: FIFO fills to 8 halfwords and requests stop
        fill_nop();
        for (int i = 0; i < 16; i++) words[i] = 32'hA000_0003 | (i << 4);
        rsp_lat = 1;
        do_reset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("full_ngnt", 32'(gnt_log.size()), 32'd4);
        check("full_req", 32'(mem_req_o), 32'd0);
        check("full_vld", 32'(instr_valid_o), 32'd1);
        check("full_ins", instr_o, 32'hA000_0003);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 6; i++)
            get_instr($sformatf("full%0d", i), 32'hA000_0003 | (i << 4), 32'(4 * i), 1'b0);

        // redirect while a request is outstanding; stale response must be dropped
        fill_nop();
        words[0]  = 32'hFFFF_FFFF;
        words[64] = 32'h4501_0000;
        rsp_lat   = 3;
        do_reset();
        instr_ready_i = 1'b1;
        wait_gnts(1);
        @(posedge clk);
        #1;
        redirect_i = 1'b1;
`ifdef FETCH_RVC_EN
        redirect_pc_i = 32'h0000_0102;
`else
        redirect_pc_i = 32'h0000_0100;
`endif
        @(negedge clk);
        check("rd_req", 32'(mem_req_o), 32'd0);
        check("rd_vld", 32'(instr_valid_o), 32'd0);
        @(posedge clk);
        #1;
        redirect_i = 1'b0;
        gnt_log.delete();
        @(negedge clk);
        check("rd_drain_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        #1;
`ifdef FETCH_RVC_EN
        get_instr("rd_a", 32'h0000_4501, 32'h102, 1'b1);
`else
        get_instr("rd_a", 32'h4501_0000, 32'h100, 1'b0);
`endif
        get_instr("rd_b", 32'h0000_0013, 32'h104, 1'b0);
        check("rd_ngnt", 32'(gnt_log.size() >= 1), 32'd1);
        if (gnt_log.size() >= 1) check("rd_addr", gnt_log[0], 32'h100);

        // reset asserted while a response is pending
        fill_nop();
        words[0] = 32'h1234_5673;
        words[1] = 32'h89AB_CDEF;
        rsp_lat  = 3;
        do_reset();
        wait_gnts(2);
        @(posedge clk);
        #1;
        check("rw_vld_pre", 32'(instr_valid_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rw_vld", 32'(instr_valid_o), 32'd0);
        check("rw_req", 32'(mem_req_o), 32'd0);
        check("rw_ins", instr_o, 32'h0);
        check("rw_addr", mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        gnt_log.delete();
        instr_ready_i = 1'b1;
        get_instr("rw_a", 32'h1234_5673, 32'h0, 1'b0);
        get_instr("rw_b", 32'h89AB_CDEF, 32'h4, 1'b0);
        check("rw_ngnt", 32'(gnt_log.size() >= 1), 32'd1);
        if (gnt_log.size() >= 1) check("rw_addr0", gnt_log[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
